// File: rtl/bsg_link_osdr_phy_multi_if.sv
// Link-side bundle of the multi-channel output SDR PHY: upstream data/valid,
// delay config, forwarded clocks, output data and the token pass-through.
`timescale 1ns/1ps
interface bsg_link_osdr_phy_multi_if #(
  parameter int width_p     = 8,
  parameter int channels_p  = 1,
  parameter int max_delay_p = 3
);
  localparam int chan_w_lp  = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam int delay_w_lp = (max_delay_p > 0) ? $clog2(max_delay_p + 1) : 1;

  logic [channels_p*width_p-1:0] data_i;
  logic [channels_p-1:0]         v_i;
  logic                          gate_en_i;
  logic                          cfg_v_i;
  logic [chan_w_lp-1:0]          cfg_chan_i;
  logic [delay_w_lp-1:0]         cfg_delay_i;
  logic                          ready_o;
  logic [channels_p-1:0]         clk_o;
  logic [channels_p*width_p-1:0] data_o;
  logic [channels_p-1:0]         token_i;
  logic [channels_p-1:0]         token_o;

  modport master (
    output data_i, v_i, gate_en_i, cfg_v_i, cfg_chan_i, cfg_delay_i, token_i,
    input  ready_o, clk_o, data_o, token_o
  );

  modport slave (
    input  data_i, v_i, gate_en_i, cfg_v_i, cfg_chan_i, cfg_delay_i, token_i,
    output ready_o, clk_o, data_o, token_o
  );
endinterface

// File: rtl/bsg_link_osdr_phy_multi.sv
// Multi-channel output SDR PHY: per-channel skew delay, centre-aligned forwarded
// clock, post-reset checkerboard training and per-channel idle clock gating.
`timescale 1ns/1ps
module bsg_link_osdr_phy_multi #(
  parameter int width_p        = 8,
  parameter int channels_p     = 1,
  parameter int max_delay_p    = 3,
  parameter int train_cycles_p = 16,
  parameter int idle_cycles_p  = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_link_osdr_phy_multi_if.slave link
);
  localparam int delay_w_lp = (max_delay_p > 0) ? $clog2(max_delay_p + 1) : 1;
  localparam int train_w_lp = (train_cycles_p > 1) ? $clog2(train_cycles_p) : 1;
  localparam int idle_w_lp  = $clog2(idle_cycles_p + 1);

  typedef enum logic [1:0] {e_reset, e_train, e_active} state_e;

  state_e                  state_r;
  logic [train_w_lp-1:0]   train_cnt_r;
  logic                    ready_r;
  logic [channels_p-1:0]   clk_en_r;
  logic [idle_w_lp-1:0]    idle_cnt_r  [channels_p];
  logic [delay_w_lp-1:0]   delay_r     [channels_p];
  logic [width_p-1:0]      data_pipe_r [channels_p][max_delay_p+1];
  logic                    valid_pipe_r[channels_p][max_delay_p+1];

  logic [width_p-1:0]            tap_data [channels_p];
  logic [channels_p-1:0]         tap_valid;
  logic [width_p-1:0]            train_word;
  logic [channels_p*width_p-1:0] data_o_n;
  logic [31:0]                   cfg_chan_ext;
  logic [31:0]                   cfg_delay_ext;
  logic [delay_w_lp-1:0]         cfg_delay_clamped;

  assign cfg_chan_ext      = 32'(link.cfg_chan_i);
  assign cfg_delay_ext     = 32'(link.cfg_delay_i);
  assign cfg_delay_clamped = (cfg_delay_ext > 32'(max_delay_p))
                             ? delay_w_lp'(max_delay_p) : link.cfg_delay_i;

  always_comb begin
    tap_valid = '0;
    for (int c = 0; c < channels_p; c++) begin
      tap_data[c] = '0;
      for (int j = 0; j <= max_delay_p; j++) begin
        if (32'(delay_r[c]) == 32'(j)) begin
          tap_data[c]  = data_pipe_r[c][j];
          tap_valid[c] = valid_pipe_r[c][j];
        end
      end
    end
  end

  // Checkerboard starts with bit0 = 1 and flips every training cycle.
  always_comb begin
    train_word = '0;
    for (int i = 0; i < width_p; i++)
      train_word[i] = (((i % 2) == 1) == train_cnt_r[0]);
  end

  always_comb begin
    data_o_n = '0;
    for (int c = 0; c < channels_p; c++) begin
      if (state_r == e_train)
        data_o_n[c*width_p +: width_p] = train_word;
      else if (state_r == e_active)
        data_o_n[c*width_p +: width_p] = tap_data[c];
    end
  end

  assign link.data_o  = data_o_n;
  assign link.ready_o = ready_r;
  assign link.token_o = link.token_i;
  // clk_en_r only moves on posedge, so gating during the high phase is glitch-free.
  assign link.clk_o   = {channels_p{~clk_i}} & clk_en_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_reset;
      train_cnt_r <= '0;
      ready_r     <= 1'b0;
      clk_en_r    <= '0;
      for (int c = 0; c < channels_p; c++) idle_cnt_r[c] <= '0;
    end else begin
      case (state_r)
        e_reset: begin
          state_r     <= e_train;
          train_cnt_r <= '0;
          clk_en_r    <= '1;
        end
        e_train: begin
          if (32'(train_cnt_r) == 32'(train_cycles_p - 1)) begin
            state_r <= e_active;
            ready_r <= 1'b1;
          end else begin
            train_cnt_r <= train_cnt_r + train_w_lp'(1);
          end
        end
        e_active: begin
          for (int c = 0; c < channels_p; c++) begin
            if (link.v_i[c]) begin
              clk_en_r[c]   <= 1'b1;
              idle_cnt_r[c] <= '0;
            end else begin
              if (tap_valid[c])
                idle_cnt_r[c] <= '0;
              else if (32'(idle_cnt_r[c]) < 32'(idle_cycles_p))
                idle_cnt_r[c] <= idle_cnt_r[c] + idle_w_lp'(1);
              if (!link.gate_en_i)
                clk_en_r[c] <= 1'b1;
              else if (32'(idle_cnt_r[c]) == 32'(idle_cycles_p))
                clk_en_r[c] <= 1'b0;
            end
          end
        end
        default: state_r <= e_reset;
      endcase
    end
  end

  // Skew pipelines shift in every state; delay writes to absent channels are dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int c = 0; c < channels_p; c++) begin
        delay_r[c] <= '0;
        for (int j = 0; j <= max_delay_p; j++) begin
          data_pipe_r[c][j]  <= '0;
          valid_pipe_r[c][j] <= 1'b0;
        end
      end
    end else begin
      for (int c = 0; c < channels_p; c++) begin
        data_pipe_r[c][0]  <= link.data_i[c*width_p +: width_p];
        valid_pipe_r[c][0] <= link.v_i[c];
        for (int j = 1; j <= max_delay_p; j++) begin
          data_pipe_r[c][j]  <= data_pipe_r[c][j-1];
          valid_pipe_r[c][j] <= valid_pipe_r[c][j-1];
        end
        if (link.cfg_v_i && (cfg_chan_ext < 32'(channels_p)) && (cfg_chan_ext == 32'(c)))
          delay_r[c] <= cfg_delay_clamped;
      end
    end
  end
endmodule

// File: tb/tb_bsg_link_osdr_phy_multi.sv
// Self-checking bench for bsg_link_osdr_phy_multi: directed phases plus random
// traffic compared against a history-based behavioural model.
`timescale 1ns/1ps
module tb_bsg_link_osdr_phy_multi;
  localparam int W  = 8;
  localparam int CH = 3;
  localparam int MD = 2;
  localparam int TR = 4;
  localparam int ID = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: phase 0 reset, 1 train, 2 active.
  int       m_phase;
  int       m_k;
  logic     m_ready;
  logic     m_en    [CH];
  int       m_idle  [CH];
  int       m_delay [CH];
  // Input history, index i = word sampled i edges ago.
  logic [CH*W-1:0] hist_d[$];
  logic [CH-1:0]   hist_v[$];
  logic [CH-1:0]   tok_drv;

  bsg_link_osdr_phy_multi_if #(.width_p(W), .channels_p(CH), .max_delay_p(MD)) link ();

  bsg_link_osdr_phy_multi #(
    .width_p(W), .channels_p(CH), .max_delay_p(MD),
    .train_cycles_p(TR), .idle_cycles_p(ID)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .link   (link)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pattern(int k);
    logic [W-1:0] p;
    for (int i = 0; i < W; i++) p[i] = ((i % 2) == (k % 2));
    return p;
  endfunction

  function automatic logic [CH*W-1:0] exp_data();
    logic [CH*W-1:0] d;
    logic [CH*W-1:0] h;
    d = '0;
    for (int c = 0; c < CH; c++) begin
      if (m_phase == 1) d[c*W +: W] = pattern(m_k);
      else if (m_phase == 2) begin
        h = hist_d[m_delay[c]];
        d[c*W +: W] = h[c*W +: W];
      end
    end
    return d;
  endfunction

  task automatic model_edge();
    logic [CH-1:0] v_old;
    logic [CH-1:0] hv;
    int nidle;
    if (reset) begin
      m_phase = 0; m_k = 0; m_ready = 1'b0;
      for (int c = 0; c < CH; c++) begin m_en[c] = 1'b0; m_idle[c] = 0; m_delay[c] = 0; end
      hist_d.delete(); hist_v.delete();
      for (int i = 0; i <= MD; i++) begin hist_d.push_front('0); hist_v.push_front('0); end
      return;
    end
    for (int c = 0; c < CH; c++) begin
      hv = hist_v[m_delay[c]];
      v_old[c] = hv[c];
    end
    case (m_phase)
      0: begin
        m_phase = 1; m_k = 0;
        for (int c = 0; c < CH; c++) m_en[c] = 1'b1;
      end
      1: begin
        if (m_k == TR - 1) begin m_phase = 2; m_ready = 1'b1; end
        else m_k++;
      end
      default: begin
        for (int c = 0; c < CH; c++) begin
          if (link.v_i[c]) begin
            m_en[c] = 1'b1; m_idle[c] = 0;
          end else begin
            nidle = v_old[c] ? 0 : ((m_idle[c] < ID) ? m_idle[c] + 1 : ID);
            if (!link.gate_en_i) m_en[c] = 1'b1;
            else if (m_idle[c] == ID) m_en[c] = 1'b0;
            m_idle[c] = nidle;
          end
        end
      end
    endcase
    hist_d.push_front(link.data_i); void'(hist_d.pop_back());
    hist_v.push_front(link.v_i);    void'(hist_v.pop_back());
    if (link.cfg_v_i && int'(link.cfg_chan_i) < CH)
      m_delay[link.cfg_chan_i] = (int'(link.cfg_delay_i) > MD) ? MD : int'(link.cfg_delay_i);
  endtask

  task automatic run_cycle();
    logic [CH-1:0] en_vec;
    @(posedge clk);
    model_edge();
    #1;
    check("data_o", 64'(link.data_o), 64'(exp_data()));
    check("ready_o", 64'(link.ready_o), 64'(m_ready));
    check("token_o", 64'(link.token_o), 64'(tok_drv));
    check("clk_o_high_phase", 64'(link.clk_o), 64'(0));
    @(negedge clk);
    #1;
    for (int c = 0; c < CH; c++) en_vec[c] = m_en[c];
    check("clk_o_low_phase", 64'(link.clk_o), 64'(en_vec));
  endtask

  task automatic apply_stimulus(input logic rst, input logic [CH*W-1:0] d,
                                input logic [CH-1:0] v, input logic gate,
                                input logic cv, input logic [1:0] cch, input logic [1:0] cdl);
    reset            = rst;
    link.data_i      = d;
    link.v_i         = v;
    link.gate_en_i   = gate;
    link.cfg_v_i     = cv;
    link.cfg_chan_i  = cch;
    link.cfg_delay_i = cdl;
    tok_drv          = CH'($urandom);
    link.token_i     = tok_drv;
  endtask

  initial begin
    logic [W-1:0] train_lit [4];
    logic [CH*W-1:0] rnd;
    train_lit[0] = 8'h55; train_lit[1] = 8'hAA; train_lit[2] = 8'h55; train_lit[3] = 8'hAA;
    for (int i = 0; i <= MD; i++) begin hist_d.push_front('0); hist_v.push_front('0); end

    // Reset with garbage on the inputs.
    for (int i = 0; i < 3; i++) begin
      rnd = {$urandom, $urandom};
      apply_stimulus(1'b1, rnd, '1, 1'b1, 1'b0, 2'd0, 2'd0);
      run_cycle();
    end

    // Training words then ready.
    for (int i = 0; i < TR; i++) begin
      apply_stimulus(1'b0, {$urandom, $urandom}, '0, 1'b1, 1'b0, 2'd0, 2'd0);
      run_cycle();
      check("train_word_ch0", 64'(link.data_o[W-1:0]), 64'(train_lit[i]));
      check("ready_low_in_train", 64'(link.ready_o), 64'(0));
    end
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 2'd0, 2'd0);
    run_cycle();
    check("ready_after_train", 64'(link.ready_o), 64'(1));

    // Delays: ch1=2, ch2 asks 3 (clamps to 2), write to channel 3 ignored.
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 2'd1, 2'd2); run_cycle();
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 2'd2, 2'd3); run_cycle();
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 2'd3, 2'd1); run_cycle();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 2'd0, 2'd0); run_cycle();
    end

    // Ramp on all channels; ch0 lags 1 cycle, ch1/ch2 lag 3.
    for (int i = 1; i <= 12; i++) begin
      apply_stimulus(1'b0, {W'(i), W'(i), W'(i)}, '1, 1'b1, 1'b0, 2'd0, 2'd0);
      run_cycle();
      check("ramp_ch0", 64'(link.data_o[W-1:0]), 64'(i));
      if (i > 2) check("ramp_ch1", 64'(link.data_o[2*W-1:W]), 64'(i - 2));
    end

    // Idle gating, then restart, with v_i arriving around the gate point.
    for (int off = 6; off <= 12; off++) begin
      for (int i = 0; i < off; i++) begin
        apply_stimulus(1'b0, {$urandom, $urandom}, '0, 1'b1, 1'b0, 2'd0, 2'd0); run_cycle();
      end
      apply_stimulus(1'b0, {$urandom, $urandom}, '1, 1'b1, 1'b0, 2'd0, 2'd0); run_cycle();
    end
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, {$urandom, $urandom}, '0, 1'b1, 1'b0, 2'd0, 2'd0); run_cycle();
    end
    check("gated_after_idle", 64'(link.clk_o), 64'(0));

    // gate_en_i low never gates.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b0, {$urandom, $urandom}, '0, 1'b0, 1'b0, 2'd0, 2'd0); run_cycle();
    end

    // Mid-traffic reset: zero output, delays back to 0, retraining.
    apply_stimulus(1'b0, {$urandom, $urandom}, '1, 1'b1, 1'b0, 2'd0, 2'd0); run_cycle();
    apply_stimulus(1'b1, {$urandom, $urandom}, '1, 1'b1, 1'b0, 2'd0, 2'd0); run_cycle();
    check("reset_data_zero", 64'(link.data_o), 64'(0));
    for (int i = 0; i < TR + 6; i++) begin
      apply_stimulus(1'b0, {$urandom, $urandom}, CH'($urandom), 1'b1, 1'b0, 2'd0, 2'd0);
      run_cycle();
    end

    // Random traffic, config and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      logic [CH-1:0] v;
      for (int c = 0; c < CH; c++) v[c] = ($urandom_range(0, 3) == 0);
      apply_stimulus(($urandom_range(0, 199) == 0), {$urandom, $urandom}, v,
                     ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                     2'($urandom), 2'($urandom));
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
